// File: rtl/scan_decoder_ctl_if.sv
// Control/status bundle for scan_decoder_ctl: 74138-style enables, mode/select/period
// inputs, and the registered one-cold strobes with index and sweep status.
interface scan_decoder_ctl_if #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DIV_W   = 16
);
  logic               g1;
  logic               g2a_n;
  logic               g2b_n;
  logic [1:0]         mode;
  logic [SEL_W-1:0]   sel;
  logic [DIV_W-1:0]   div;
  logic               start;
  logic [NUM_OUT-1:0] y_n;
  logic [SEL_W-1:0]   idx;
  logic               busy;
  logic               done;

  modport master (
    output g1, g2a_n, g2b_n, mode, sel, div, start,
    input  y_n, idx, busy, done
  );

  modport slave (
    input  g1, g2a_n, g2b_n, mode, sel, div, start,
    output y_n, idx, busy, done
  );
endinterface

// File: rtl/scan_decoder_ctl.sv
// Registered 1-of-N active-low decoder with a 3-input enable: direct select,
// continuous prescaled scan, or a single START-triggered sweep.
module scan_decoder_ctl #(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 8,
  parameter int DIV_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  scan_decoder_ctl_if.slave bus
);

  typedef enum logic { IDLE, SWEEP } state_t;

  localparam logic [1:0]       MODE_SCAN  = 2'b01;
  localparam logic [1:0]       MODE_SWEEP = 2'b10;
  localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(NUM_OUT - 1);

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [SEL_W-1:0]   idx_q, idx_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [NUM_OUT-1:0] y_n_q, y_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               en;
  logic               step;
  logic               show;

  // Out-of-range indices fall through the loop and leave every output high.
  function automatic logic [NUM_OUT-1:0] one_cold(input logic [SEL_W-1:0] i);
    logic [NUM_OUT-1:0] v;
    v = '1;
    for (int k = 0; k < NUM_OUT; k++)
      if (k == int'(i)) v[k] = 1'b0;
    return v;
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    en      = bus.g1 & ~bus.g2a_n & ~bus.g2b_n;
    step    = (presc_q >= bus.div);
    state_d = state_q;
    idx_d   = idx_q;
    presc_d = presc_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    show    = 1'b0;

    case (bus.mode)
      MODE_SCAN: begin
        state_d = IDLE;
        show    = en;
        if (mode_q != MODE_SCAN) begin
          idx_d   = '0;
          presc_d = '0;
        end else if (en) begin
          if (step) begin
            presc_d = '0;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end

      MODE_SWEEP: begin
        if (state_q == IDLE) begin
          idx_d   = '0;
          presc_d = '0;
          if (bus.start && en) begin
            state_d = SWEEP;
            busy_d  = 1'b1;
            show    = 1'b1;
          end
        end else begin
          busy_d = 1'b1;
          if (en) begin
            if (!step) begin
              presc_d = presc_q + 1'b1;
              show    = 1'b1;
            end else if (idx_q == LAST_IDX) begin
              state_d = IDLE;
              presc_d = '0;
              idx_d   = '0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              presc_d = '0;
              idx_d   = idx_q + 1'b1;
              show    = 1'b1;
            end
          end
        end
      end

      // 00 and 11 both decode SEL directly; leaving a sweep here aborts it silently.
      default: begin
        state_d = IDLE;
        idx_d   = bus.sel;
        presc_d = '0;
        show    = en;
      end
    endcase

    y_n_d = show ? one_cold(idx_d) : '1;
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge and only touches control state; no memories here.
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      idx_q   <= '0;
      presc_q <= '0;
      y_n_q   <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep all state updates on the same edge.
      state_q <= state_d;
      mode_q  <= bus.mode;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      y_n_q   <= y_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.y_n  = y_n_q;
  assign bus.idx  = idx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_scan_decoder_ctl.sv
// Directed bench for scan_decoder_ctl: an 8-output instance for the main scenarios
// and a 6-output instance for the non-power-of-two boundary.
module tb_scan_decoder_ctl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  scan_decoder_ctl_if #(.SEL_W(3), .NUM_OUT(8), .DIV_W(16)) bus8 ();
  scan_decoder_ctl_if #(.SEL_W(3), .NUM_OUT(6), .DIV_W(16)) bus6 ();

  scan_decoder_ctl #(.SEL_W(3), .NUM_OUT(8), .DIV_W(16)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  scan_decoder_ctl #(.SEL_W(3), .NUM_OUT(6), .DIV_W(16)) dut6 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cold8(input int i);
    logic [7:0] v;
    v = ~(8'd1 << i);
    return v;
  endfunction

  function automatic logic [5:0] cold6(input int i);
    logic [5:0] v;
    v = ~(6'd1 << i);
    return v;
  endfunction

  int busy_cnt;
  int done_cnt;
  int last_idx;
  int e;

  initial begin
    rst_n = 1'b0;
    bus8.g1 = 1'b1; bus8.g2a_n = 1'b0; bus8.g2b_n = 1'b0;
    bus8.mode = 2'b00; bus8.sel = '0; bus8.div = '0; bus8.start = 1'b0;
    bus6.g1 = 1'b1; bus6.g2a_n = 1'b0; bus6.g2b_n = 1'b0;
    bus6.mode = 2'b00; bus6.sel = '0; bus6.div = '0; bus6.start = 1'b0;
    tick();
    tick();
    check("rst_y_n",  32'(bus8.y_n),  32'hFF);
    check("rst_idx",  32'(bus8.idx),  32'd0);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_y6",   32'(bus6.y_n),  32'h3F);
    rst_n = 1'b1;

    // Direct decode, then disable through G2A_N.
    bus8.sel = 3'd5;
    tick();
    check("dir_y_n", 32'(bus8.y_n), 32'hDF);
    check("dir_idx", 32'(bus8.idx), 32'd5);
    bus8.g2a_n = 1'b1;
    tick();
    check("dir_dis_y_n", 32'(bus8.y_n), 32'hFF);
    bus8.g2a_n = 1'b0;

    // Continuous scan, DIV=2: each index held 3 cycles, wraps after 24.
    bus8.div = 16'd2; bus8.mode = 2'b01;
    tick();
    check("scan_entry_y", 32'(bus8.y_n), 32'hFE);
    check("scan_entry_i", 32'(bus8.idx), 32'd0);
    for (int c = 1; c <= 26; c++) begin
      tick();
      e = (c / 3) % 8;
      check($sformatf("scan_idx_c%0d", c), 32'(bus8.idx), 32'(e));
      check($sformatf("scan_y_c%0d", c),   32'(bus8.y_n), 32'(cold8(e)));
    end

    // Sweep, DIV=0, single-cycle START.
    bus8.div = 16'd0; bus8.mode = 2'b10;
    tick();
    check("sw_idle_y",    32'(bus8.y_n),  32'hFF);
    check("sw_idle_idx",  32'(bus8.idx),  32'd0);
    check("sw_idle_busy", 32'(bus8.busy), 32'd0);
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    check("sw_start_y",    32'(bus8.y_n),  32'hFE);
    check("sw_start_busy", 32'(bus8.busy), 32'd1);
    for (int s = 1; s < 8; s++) begin
      tick();
      check($sformatf("sw_y_s%0d", s),    32'(bus8.y_n),  32'(cold8(s)));
      check($sformatf("sw_busy_s%0d", s), 32'(bus8.busy), 32'd1);
      check($sformatf("sw_done_s%0d", s), 32'(bus8.done), 32'd0);
    end
    tick();
    check("sw_end_done", 32'(bus8.done), 32'd1);
    check("sw_end_busy", 32'(bus8.busy), 32'd0);
    check("sw_end_y",    32'(bus8.y_n),  32'hFF);
    check("sw_end_idx",  32'(bus8.idx),  32'd0);
    tick();
    check("sw_post_done", 32'(bus8.done), 32'd0);
    check("sw_post_y",    32'(bus8.y_n),  32'hFF);

    // START held high: ignored on the completion edge, re-triggers one cycle later.
    bus8.start = 1'b1;
    tick();
    for (int s = 1; s < 8; s++) tick();
    tick();
    check("rt_done", 32'(bus8.done), 32'd1);
    check("rt_busy", 32'(bus8.busy), 32'd0);
    tick();
    check("rt_again_busy", 32'(bus8.busy), 32'd1);
    check("rt_again_y",    32'(bus8.y_n),  32'hFE);
    bus8.start = 1'b0;

    // Abort by leaving sweep mode: no DONE, direct decode on the same edge.
    tick();
    bus8.mode = 2'b00; bus8.sel = 3'd2;
    tick();
    check("abort_busy", 32'(bus8.busy), 32'd0);
    check("abort_done", 32'(bus8.done), 32'd0);
    check("abort_y",    32'(bus8.y_n),  32'hFB);
    check("abort_idx",  32'(bus8.idx),  32'd2);
    bus8.mode = 2'b10;
    tick();

    // Sweep DIV=1 paused for 5 cycles at IDX=3.
    bus8.div = 16'd1; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    busy_cnt = int'(bus8.busy);
    for (int c = 1; c <= 6; c++) begin
      tick();
      busy_cnt += int'(bus8.busy);
    end
    check("pause_at_idx", 32'(bus8.idx), 32'd3);
    check("pause_at_y",   32'(bus8.y_n), 32'hF7);
    bus8.g1 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      busy_cnt += int'(bus8.busy);
      check($sformatf("pause_y_%0d", c),    32'(bus8.y_n),  32'hFF);
      check($sformatf("pause_idx_%0d", c),  32'(bus8.idx),  32'd3);
      check($sformatf("pause_busy_%0d", c), 32'(bus8.busy), 32'd1);
    end
    bus8.g1 = 1'b1;
    done_cnt = 0;
    last_idx = 3;
    for (int c = 0; c < 40 && done_cnt == 0; c++) begin
      tick();
      busy_cnt += int'(bus8.busy);
      if (bus8.done) done_cnt++;
      if (bus8.busy && int'(bus8.idx) != last_idx) begin
        check("pause_no_skip", 32'(bus8.idx), 32'(last_idx + 1));
        last_idx = int'(bus8.idx);
      end
    end
    check("pause_busy_total", 32'(busy_cnt), 32'd21);
    check("pause_done_seen",  32'(done_cnt), 32'd1);
    check("pause_last_idx",   32'(last_idx), 32'd7);

    // Reset in the middle of a sweep.
    bus8.div = 16'd0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("rsw_pre_idx", 32'(bus8.idx), 32'd4);
    rst_n = 1'b0;
    tick();
    check("rsw_y",    32'(bus8.y_n),  32'hFF);
    check("rsw_idx",  32'(bus8.idx),  32'd0);
    check("rsw_busy", 32'(bus8.busy), 32'd0);
    check("rsw_done", 32'(bus8.done), 32'd0);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      done_cnt += int'(bus8.done);
    end
    check("rsw_no_done", 32'(done_cnt), 32'd0);

    // Six-output instance: out-of-range select and wrap at 5.
    bus6.sel = 3'd7;
    tick();
    check("n6_sel7_y",   32'(bus6.y_n), 32'h3F);
    check("n6_sel7_idx", 32'(bus6.idx), 32'd7);
    bus6.sel = 3'd5;
    tick();
    check("n6_sel5_y", 32'(bus6.y_n), 32'h1F);
    bus6.mode = 2'b01;
    tick();
    check("n6_entry_y", 32'(bus6.y_n), 32'h3E);
    for (int c = 1; c <= 7; c++) begin
      tick();
      e = c % 6;
      check($sformatf("n6_idx_c%0d", c), 32'(bus6.idx), 32'(e));
      check($sformatf("n6_y_c%0d", c),   32'(bus6.y_n), 32'(cold6(e)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
